// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds two W-bit operands (W = 4*NIBBLES) with one shared 4-bit ripple
//   adder. It processes one nibble per clock, starting with the least
//   significant nibble. The carry between nibbles is held in a register.
//   The result is published all at once on the completion edge.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-high
//   start : request; sampled only in IDLE or DONE
//   A, B  : W-bit operands, captured on the accepting edge
//   Cin   : carry into nibble 0, captured on the accepting edge
//   busy  : high while nibbles are being processed
//   done  : one-cycle pulse; Sum/Cout/Ovf were updated on the same edge
//   Sum   : registered result, held until the next completion
//   Cout  : registered carry out of the top nibble
//   Ovf   : registered two's-complement overflow flag

// Plain 4-bit ripple-carry adder. This is the shared datapath slice.
module full_adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [4:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout,
  output logic                 Ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            c_q, c_d;
  logic [W-1:0]    part_q, part_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      add_sum;
  logic            add_cout;

  // The single shared slice always works on the nibble selected by idx_q.
  full_adder_4_bit u_adder (
    .A    (a_q[4*idx_q +: 4]),
    .B    (b_q[4*idx_q +: 4]),
    .Cin  (c_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    // NOTE: every variable gets a default here before any branch. An
    // always_comb that leaves a path unassigned would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    part_d  = part_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      // DONE accepts a new request exactly like IDLE. This gives
      // back-to-back operations every NIBBLES+1 cycles.
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          part_d  = '0;
          idx_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        part_d[4*idx_q +: 4] = add_sum;
        c_d                  = add_cout;
        if (idx_q == LAST_IDX) begin
          // The top nibble goes straight into the published result.
          // part_q does not hold that nibble yet on this edge.
          sum_d          = part_q;
          sum_d[W-1 -: 4] = add_sum;
          cout_d         = add_cout;
          ovf_d          = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
          idx_d          = '0;
          state_d        = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      part_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from their pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // busy and done decode the state register directly. A reset therefore
  // clears them at once, and done lasts exactly the one DONE cycle.
  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two wide operands using a single instance of the existing 4-bit ripple adder (full_adder_4_bit), one nibble per clock, LSB nibble first.
- Carry is chained through a register between nibbles.
- Start/busy/done handshake. Result is presented atomically on completion.
- Sits between a control FSM or host and the shared 4-bit adder datapath. Trades area for latency.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only when accepting (IDLE or DONE)
- A  input  W  operand A; sampled on accepting edge only
- B  input  W  operand B; sampled on accepting edge only
- Cin  input  1  carry-in to nibble 0; sampled on accepting edge only
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse: Sum/Cout/Ovf valid and updated
- Sum  output  W  registered result, held until next completion
- Cout  output  1  registered carry-out of top nibble
- Ovf  output  1  registered signed overflow flag

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; internal operand, partial-sum, carry and index registers cleared.
- Reset mid-operation aborts the operation. No done is produced, and outputs return to reset values.
- State IDLE:
  - start=1 at the edge: latch A, B, Cin into a_q, b_q, c_q; idx=0; part=0; go to ADD; busy=1.
  - start=0: stay in IDLE.
- State ADD:
  - The adder sees A=a_q[4*idx+:4], B=b_q[4*idx+:4], Cin=c_q.
  - Each edge: part[4*idx+:4] <= adder Sum; c_q <= adder Cout; idx <= idx+1.
  - At the edge where idx==NIBBLES-1:
    - Sum <= part with top nibble inserted; Cout <= adder Cout.
    - Ovf <= (a_q[W-1]==b_q[W-1]) && (result[W-1]!=a_q[W-1]).
    - done <= 1; busy <= 0; go to DONE.
- State DONE (lasts exactly one cycle):
  - done=1.
  - start=1 at the edge: accept a new operation exactly as from IDLE; done <= 0.
  - start=0: go to IDLE; done <= 0.
- start while busy=1 is ignored, not queued. A, B and Cin changes during ADD have no effect.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+NIBBLES.
- Throughput: one operation per NIBBLES+1 cycles with back-to-back start.
- Sum, Cout and Ovf change only on the done edge (or reset); no intermediate values are visible.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(W+1). Ovf is meaningful for two's-complement interpretation.
- idx width = clog2(NIBBLES); no wrap beyond NIBBLES-1.

Test Plan (NIBBLES=4):
- Reset asserted, then 0x0000+0x0000, Cin=0 → done 4 edges after start; Sum=0x0000, Cout=0, Ovf=0; busy high for exactly 4 cycles.
- 0x00FF+0x0001, Cin=0 → Sum=0x0100 (carry ripples across nibble boundary), Cout=0, Ovf=0. Also 0x1234+0x4321, Cin=1 → Sum=0x5556.
- 0xFFFF+0x0001 → Sum=0x0000, Cout=1, Ovf=0. Then 0x7FFF+0x0001 → Sum=0x8000, Cout=0, Ovf=1. Then 0x8000+0x8000 → Sum=0x0000, Cout=1, Ovf=1.
- Start op 0x0001+0x0001, then pulse start with A=0xAAAA on the 2nd busy cycle → ignored; result 0x0002. Change A/B mid-ADD → result unaffected.
- Start held high continuously → done every 5 cycles; operands changed each done cycle produce the matching sums; Sum stable between done pulses.
- rst asserted asynchronously (between clock edges) during the 3rd ADD cycle → all outputs 0 immediately; no done pulse; next start completes normally.
